// File: rtl/rc5_dec_arbiter.sv
// Round-robin front end for one shared RC5 decrypt core. A block is accepted in IDLE, and its response appears 16 cycles later.
// Both requesters stall while a block is in flight, and the response is held until rsp_ready.
module rc5_dec_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req0_valid,
  input  logic [63:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [63:0] req1_data,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_id,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic        core_clr_n,
  output logic        core_din_valid,
  output logic [63:0] core_din,
  input  logic        core_dout_ready,
  input  logic [63:0] core_dout
);

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, FLUSH, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        cur_id;
  logic        grant;
  logic        wdog_expired;
  logic [7:0]  wdog;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign req0_ready     = !clr && (state == IDLE) && !grant && req0_valid;
  assign req1_ready     = !clr && (state == IDLE) &&  grant && req1_valid;
  assign rsp_valid      = !clr && (state == RESP);
  assign rsp_id         = cur_id;
  assign core_din_valid = !clr && (state == LAUNCH);
  assign core_clr_n     = !(clr || (state == FLUSH));
  assign wdog_expired   = (wdog == WDOG_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req0_ready || req1_ready) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT: begin
        if (core_dout_ready)   state_nxt = RESP;
        else if (wdog_expired) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_id     <= 1'b0;
      wdog       <= 8'd0;
      core_din   <= 64'd0;
      rsp_data   <= 64'd0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req0_ready) begin
            core_din <= req0_data;
            cur_id   <= 1'b0;
          end else if (req1_ready) begin
            core_din <= req1_data;
            cur_id   <= 1'b1;
          end
        end
        LAUNCH: wdog <= 8'd0;
        WAIT: begin
          wdog <= wdog + 8'd1;
          // A completion landing on the timeout cycle still counts as success.
          if (core_dout_ready) begin
            rsp_data <= core_dout;
            rsp_err  <= 1'b0;
          end else if (wdog_expired) begin
            rsp_data <= 64'd0;
            rsp_err  <= 1'b1;
          end
        end
        RESP: if (rsp_ready) last_grant <= cur_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_dec_arbiter.sv
// Randomized bench for rc5_dec_arbiter with a behavioural RC5-32/12/16 core (all-zero key).
// A transaction-level model checks grants, latency, responses, core strobes and resets on every cycle.
module tb_rc5_dec_arbiter;
  localparam int TIMEOUT = 16;
  localparam int LAT_OK  = 16;
  localparam int LAT_TO  = TIMEOUT + 3;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [63:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_err;
  logic [63:0] rsp_data;
  logic        rsp_ready = 1'b1;
  logic        core_clr_n, core_din_valid, core_dout_ready;
  logic [63:0] core_din, core_dout;

  rc5_dec_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .clr(clr),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready),
    .core_clr_n(core_clr_n), .core_din_valid(core_din_valid), .core_din(core_din),
    .core_dout_ready(core_dout_ready), .core_dout(core_dout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // ---------------- RC5-32/12/16 reference, key = 16 zero bytes ----------------
  logic [31:0] rk [0:25];

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (32 - int'(n)));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (32 - int'(n)));
  endfunction

  task automatic key_setup();
    logic [31:0] lk [0:3];
    logic [31:0] a, b, t;
    int i, j;
    rk[0] = 32'hB7E15163;
    for (int k = 1; k < 26; k++) rk[k] = rk[k-1] + 32'h9E3779B9;
    for (int k = 0; k < 4; k++) lk[k] = 32'd0;
    a = 0; b = 0; i = 0; j = 0;
    for (int k = 0; k < 78; k++) begin
      a = rotl(rk[i] + a + b, 5'd3);
      rk[i] = a;
      t = a + b;
      b = rotl(lk[j] + t, t[4:0]);
      lk[j] = b;
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
  endtask

  function automatic logic [63:0] rc5_dec(input logic [63:0] c);
    logic [31:0] a, b;
    a = c[63:32];
    b = c[31:0];
    for (int r = 12; r >= 1; r--) begin
      b = rotr(b - rk[2*r+1], a[4:0]) ^ a;
      a = rotr(a - rk[2*r], b[4:0]) ^ b;
    end
    return {a - rk[0], b - rk[1]};
  endfunction

  // ---------------- core model: result 14 cycles after the launch cycle ----------------
  logic        dead = 1'b0;
  logic        spur = 1'b0;
  logic [63:0] spur_dat = '0;
  logic        c_busy = 1'b0, c_rdy = 1'b0;
  logic [3:0]  c_cnt = '0;
  logic [63:0] c_in = '0, c_out = '0;

  always @(posedge clk) begin
    c_rdy <= 1'b0;
    if (!core_clr_n) c_busy <= 1'b0;
    else if (core_din_valid) begin
      c_busy <= 1'b1;
      c_cnt  <= 4'd0;
      c_in   <= core_din;
    end else if (c_busy) begin
      c_cnt <= c_cnt + 4'd1;
      if (c_cnt == 4'd12) begin
        c_busy <= 1'b0;
        if (!dead) begin
          c_rdy <= 1'b1;
          c_out <= rc5_dec(c_in);
        end
      end
    end
  end

  assign core_dout_ready = c_rdy | spur;
  assign core_dout       = spur ? spur_dat : c_out;

  // ---------------- transaction model and per-cycle checks ----------------
  int          cyc = 0;
  bit          busy = 0, m_last = 1, m_id = 0, m_dead = 0, m_rv = 0;
  int          t0 = 0, lat = LAT_OK, n_done = 0;
  logic [63:0] m_data = '0, m_rsp = '0, last_rsp = '0;
  bit          acc0 = 0, acc1 = 0;
  int          glog [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit eg, e_r0, e_r1, e_rv, e_dv, e_cn, idle_now;
    if (cyc > 0) begin
      eg       = (req0_valid && req1_valid) ? !m_last : req1_valid;
      idle_now = !busy && !clr;
      e_r0     = idle_now && req0_valid && !eg;
      e_r1     = idle_now && req1_valid && eg;
      e_rv     = busy && !clr && (cyc >= t0 + lat);
      e_dv     = busy && !clr && (cyc == t0 + 1);
      e_cn     = !(clr || (busy && m_dead && cyc == t0 + TIMEOUT + 2));
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("core_din_valid", core_din_valid, e_dv);
      chk("core_clr_n", core_clr_n, e_cn);
      if (busy && !clr && cyc >= t0 + 1) chk("core_din", core_din, m_data);
      if (e_rv) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_err", rsp_err, m_dead);
        chk("rsp_data", rsp_data, m_rsp);
      end
      m_rv = e_rv;
      if (clr) begin
        busy   = 0;
        m_last = 1;
      end else begin
        if (e_rv && rsp_ready) begin
          busy     = 0;
          m_last   = m_id;
          last_rsp = m_rsp;
          n_done++;
        end
        if (e_r0 || e_r1) begin
          busy   = 1;
          t0     = cyc;
          m_id   = e_r1;
          m_data = e_r1 ? req1_data : req0_data;
          m_dead = dead;
          lat    = dead ? LAT_TO : LAT_OK;
          m_rsp  = dead ? 64'd0 : rc5_dec(m_data);
          glog.push_back(int'(e_r1));
        end
      end
      acc0 = e_r0;
      acc1 = e_r1;
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    acc0 = 0;
    acc1 = 0;
    clr  = 1'b0;
    spur = 1'b0;
    req0_valid = (q0.size() > 0);
    req1_valid = (q1.size() > 0);
    if (req0_valid) req0_data = q0[0];
    if (req1_valid) req1_data = q1[0];
  endtask

  task automatic wait_done(input string tag, input int target, input int limit);
    int n = 0;
    while (n_done < target && n < limit) begin
      tick();
      n++;
    end
    chk(tag, n_done, target);
  endtask

  task automatic wait_rsp(input string tag, input int limit);
    int n = 0;
    while (!rsp_valid && n < limit) begin
      tick();
      n++;
    end
    chk(tag, rsp_valid, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    bit spur_ok;
    key_setup();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_core_din", core_din, 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    clr = 1'b0;

    // Spurious completion in IDLE must leave the response registers alone.
    tick();
    spur = 1'b1;
    spur_dat = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    chk("spur_idle_data", rsp_data, 64'd0);
    chk("spur_idle_err", rsp_err, 1'b0);

    // Single request with known data.
    q0.push_back(64'h0123456789ABCDEF);
    wait_done("single_done", 1, 40);

    // Watchdog abort, then a normal completion.
    dead = 1'b1;
    q0.push_back(64'h1111_2222_3333_4444);
    wait_done("wdog_done", 2, 60);
    dead = 1'b0;
    q1.push_back(64'h5555_6666_7777_8888);
    wait_done("after_wdog_done", 3, 40);

    // Tie: both always valid right after reset, grant must alternate from 0.
    clr = 1'b1;
    tick();
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(64'hA0A0_0000_0000_0000 + 64'(i));
      q1.push_back(64'hB1B1_0000_0000_0000 + 64'(i));
    end
    wait_done("tie_done", 11, 300);
    chk("tie_grants", glog.size(), 8);
    for (int i = 0; i < glog.size() && i < 8; i++) chk($sformatf("tie_grant%0d", i), glog[i], i % 2);

    // Response backpressure with requester 1 waiting.
    rsp_ready = 1'b0;
    q0.push_back(64'hFEDC_BA98_7654_3210);
    q1.push_back(64'h0F0F_0F0F_F0F0_F0F0);
    wait_rsp("bp_rsp", 40);
    repeat (10) tick();
    rsp_ready = 1'b1;
    wait_done("bp_done", 13, 60);

    // Reset at T0+8 drops the transaction silently.
    q0.push_back(64'h1357_9BDF_2468_ACE0);
    begin
      int n = 0;
      while (!core_din_valid && n < 20) begin
        tick();
        n++;
      end
    end
    chk("rst_mid_launch", core_din_valid, 1'b1);
    repeat (7) tick();
    clr = 1'b1;
    base = n_done;
    repeat (30) tick();
    chk("rst_mid_no_rsp", n_done, base);
    q1.push_back(64'h0246_8ACE_1357_9BDF);
    wait_done("rst_mid_after", base + 1, 40);

    // Spurious completion while the response is held.
    rsp_ready = 1'b0;
    q0.push_back(64'h7777_0000_9999_1111);
    wait_rsp("spur_resp_rsp", 40);
    spur = 1'b1;
    spur_dat = 64'h0BAD_0BAD_0BAD_0BAD;
    repeat (3) tick();
    rsp_ready = 1'b1;
    wait_done("spur_resp_done", base + 2, 20);
    tick();
    spur = 1'b1;
    spur_dat = 64'h1234_1234_1234_1234;
    tick();
    chk("spur_idle2_data", rsp_data, last_rsp);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (q0.size() == 0 && $urandom_range(0, 3) == 0) q0.push_back({$urandom, $urandom});
      if (q1.size() == 0 && $urandom_range(0, 3) == 0) q1.push_back({$urandom, $urandom});
      rsp_ready = ($urandom_range(0, 9) < 7);
      spur_ok = !busy || (cyc <= t0 + 1) || (cyc >= t0 + lat);
      if (spur_ok && $urandom_range(0, 19) == 0) begin
        spur = 1'b1;
        spur_dat = {$urandom, $urandom};
      end
      if ($urandom_range(0, 299) == 0) clr = 1'b1;
    end

    rsp_ready = 1'b1;
    begin
      int n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || busy) && n < 3000) begin
        tick();
        n++;
      end
    end
    chk("drain_left", q0.size() + q1.size() + int'(busy), 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
